tl_traffic_gen: RTL
===================

Name: tl_traffic_gen

Overview:
- Synthesizable, parametrised traffic generator and checker for the transaction layer.
- Replaces hand-sequenced stimulus with a programmable run.
- Drives configuration (thresholds, init), pushes a deterministic word stream into the DUT input FIFO, and pops all NUM_PORTS output FIFOs concurrently.
- Checks every returned word against the expected per-port sequence and reports receive and error counts.

Parameters:
- DATA_W, 12, width of the FIFO data word.
- NUM_PORTS, 4, number of output ports; power of two, ≥2.
- DEST_W, 2, log2(NUM_PORTS); destination field is data[DATA_W-1 -: DEST_W].
- CNT_W, 16, width of word counters.
- SEED, 15, payload of word 0.
- UMBRAL_BAJO, 1, low threshold driven to the DUT (3 bits).
- UMBRAL_ALTO, 6, high threshold driven to the DUT (3 bits).
- INIT_WAIT, 3, idle cycles after the init pulse before the first push.
- TIMEOUT, 255, drain cycles without any pop before the run is abandoned.

Ports:
- clk  in  1  single clock, all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin run; sampled in IDLE/DONE only.
- cfg_num_words  in  CNT_W  words to send; 0 is legal.
- cfg_gap  in  4  idle cycles inserted after each push.
- fifo_almost_full  in  1  DUT input FIFO backpressure.
- outEmpty  in  NUM_PORTS  per-port output FIFO empty.
- dataOutput  in  NUM_PORTS*DATA_W  per-port read data; port p at [p*DATA_W +: DATA_W]; valid 1 cycle after pop.
- Umbral_bajo  out  3  low threshold.
- Umbral_alto  out  3  high threshold.
- init  out  1  one-cycle DUT init pulse.
- pushIn  out  1  push strobe.
- dataInputFIFO  out  DATA_W  pushed word.
- popOut  out  NUM_PORTS  per-port pop strobes.
- busy  out  1  run in progress.
- done  out  1  run finished; held until next start.
- timeout  out  1  run ended by TIMEOUT.
- rx_count  out  CNT_W  words received.
- err_count  out  CNT_W  mismatches; saturating.

Behaviour:
- Reset (async, reset=0):
  - state IDLE.
  - All outputs 0, including Umbral_*, counters and flags.
  - Reset mid-run aborts immediately; no partial pulse survives.
- Outputs are registered.
- FSM: IDLE -> CFG -> INIT -> WAIT -> PUSH -> DRAIN -> DONE.
  - IDLE / DONE: on start=1, clear rx_count, err_count, done, timeout and sent count; go CFG.
  - CFG (1 cycle): Umbral_bajo=UMBRAL_BAJO, Umbral_alto=UMBRAL_ALTO. These stay driven until reset.
  - INIT (1 cycle): init=1.
  - WAIT: INIT_WAIT cycles, then PUSH; if cfg_num_words=0, go directly to DRAIN.
  - PUSH: push when gap counter=0 and fifo_almost_full=0.
    - Word k: dest=k mod NUM_PORTS, payload=(SEED+k) mod 2^(DATA_W-DEST_W).
    - After each push, gap counter loads cfg_gap.
    - After push number cfg_num_words, go DRAIN.
    - fifo_almost_full=1 holds pushIn=0 and freezes the gap counter.
  - DRAIN: stay until rx_count==cfg_num_words, then go DONE.
    - If TIMEOUT consecutive cycles pass without a pop, set timeout=1 and go DONE.
  - DONE: done=1, busy=0.
- busy=1 in states CFG through DRAIN. start is ignored while busy.
- Checker (active in PUSH and DRAIN):
  - popOut[p]=!outEmpty[p] every cycle; back-to-back pops allowed.
  - A pop in cycle n means dataOutput[p] is compared in cycle n+1.
  - Per-port expected register exp[p], initialised to SEED+p at start, advanced by NUM_PORTS (mod payload width) per compare.
  - Mismatch if dest field != p or payload != exp[p]; err_count increments, saturating at all-ones.
  - rx_count increments once per compared word; multiple ports in one cycle add their popcount.
- The compare pipeline drains fully before DONE: the last pop's compare is counted.
- Simultaneous push and pops in the same cycle are independent.
- cfg_num_words and cfg_gap are latched at start; later changes have no effect on the run.

Test Plan:
- Basic run, cfg_num_words=8, cfg_gap=0, loopback model routing by dest:
  - dataInputFIFO sequence 15, 0x410, 0x811, 0xC12, ...
  - port 0 returns 15, 19; port 1 returns 16, 20 (payloads); rx_count=8, err_count=0, done=1.
- cfg_gap=1 -> pushIn toggles 1,0,1,0; 8 words take 15 cycles of PUSH.
- Hold fifo_almost_full=1 for 5 cycles mid-run -> no push during those cycles, stream resumes with the next k, final err_count=0.
- Model corrupts the 3rd word on port 2 -> err_count=1, rx_count=8.
- Model drops one word -> DRAIN ends after TIMEOUT=255 idle cycles: timeout=1, done=1, rx_count=7.
- cfg_num_words=0 -> CFG, INIT pulse, WAIT, DRAIN, DONE; no push.
- Assert reset low during PUSH -> all outputs 0 asynchronously; start after release runs cleanly.

Source files
------------

// File: rtl/tl_traffic_gen.sv
// Transaction-layer traffic generator/checker: programs thresholds, pulses init,
// pushes a deterministic word stream and checks every word returned per output port.
module tl_traffic_gen #(
    parameter int unsigned DATA_W      = 12,
    parameter int unsigned NUM_PORTS   = 4,
    parameter int unsigned DEST_W      = 2,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SEED        = 15,
    parameter int unsigned UMBRAL_BAJO = 1,
    parameter int unsigned UMBRAL_ALTO = 6,
    parameter int unsigned INIT_WAIT   = 3,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [CNT_W-1:0]            cfg_num_words,
    input  logic [3:0]                  cfg_gap,
    input  logic                        fifo_almost_full,
    input  logic [NUM_PORTS-1:0]        outEmpty,
    input  logic [NUM_PORTS*DATA_W-1:0] dataOutput,
    output logic [2:0]                  Umbral_bajo,
    output logic [2:0]                  Umbral_alto,
    output logic                        init,
    output logic                        pushIn,
    output logic [DATA_W-1:0]           dataInputFIFO,
    output logic [NUM_PORTS-1:0]        popOut,
    output logic                        busy,
    output logic                        done,
    output logic                        timeout,
    output logic [CNT_W-1:0]            rx_count,
    output logic [CNT_W-1:0]            err_count
);
    localparam int unsigned PAY_W  = DATA_W - DEST_W;
    localparam int unsigned WAIT_W = (INIT_WAIT < 2) ? 1 : $clog2(INIT_WAIT);
    localparam int unsigned IDLE_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG,
        ST_INIT,
        ST_WAIT,
        ST_PUSH,
        ST_DRAIN,
        ST_DONE
    } state_e;

    state_e                          state_q, state_d;
    logic [2:0]                      umb_lo_q, umb_lo_d;
    logic [2:0]                      umb_hi_q, umb_hi_d;
    logic                            init_q, init_d;
    logic                            push_q, push_d;
    logic [DATA_W-1:0]               data_q, data_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic                            tout_q, tout_d;
    logic [CNT_W-1:0]                rx_q, rx_d;
    logic [CNT_W-1:0]                err_q, err_d;
    logic [CNT_W-1:0]                num_q, num_d;
    logic [CNT_W-1:0]                sent_q, sent_d;
    logic [3:0]                      gap_cfg_q, gap_cfg_d;
    logic [3:0]                      gap_q, gap_d;
    logic [WAIT_W-1:0]               wait_q, wait_d;
    logic [IDLE_W-1:0]               idle_q, idle_d;
    logic [NUM_PORTS-1:0][PAY_W-1:0] exp_q, exp_d;
    logic [NUM_PORTS-1:0]            pop_q, pop_d;

    logic                            chk_active;
    logic [NUM_PORTS-1:0]            pop_c;
    logic [DATA_W-1:0]               cmp_word;
    logic [DATA_W-1:0]               push_word;
    logic [CNT_W-1:0]                sent_inc;
    logic [CNT_W-1:0]                rx_inc;
    logic [CNT_W-1:0]                err_inc;
    logic [CNT_W:0]                  err_sum;

    // Pops follow the FIFO empty flags directly so back-to-back pops never overrun a FIFO.
    assign chk_active = (state_q == ST_PUSH) || (state_q == ST_DRAIN);
    assign pop_c      = ~outEmpty & {NUM_PORTS{chk_active}};

    always_comb begin
        state_d   = state_q;
        umb_lo_d  = umb_lo_q;
        umb_hi_d  = umb_hi_q;
        push_d    = 1'b0;
        data_d    = data_q;
        tout_d    = tout_q;
        rx_d      = rx_q;
        err_d     = err_q;
        num_d     = num_q;
        sent_d    = sent_q;
        gap_cfg_d = gap_cfg_q;
        gap_d     = gap_q;
        wait_d    = wait_q;
        idle_d    = idle_q;
        exp_d     = exp_q;
        pop_d     = pop_c;
        cmp_word  = '0;
        rx_inc    = '0;
        err_inc   = '0;
        push_word = {DEST_W'(sent_q), PAY_W'(SEED) + PAY_W'(sent_q)};
        sent_inc  = sent_q + CNT_W'(1);

        // Compare stage: data for a port popped last cycle is valid now.
        for (int p = 0; p < NUM_PORTS; p++) begin
            cmp_word = dataOutput[p*DATA_W +: DATA_W];
            if (pop_q[p]) begin
                rx_inc = rx_inc + CNT_W'(1);
                if ((cmp_word[DATA_W-1 -: DEST_W] != DEST_W'(p)) ||
                    (cmp_word[PAY_W-1:0] != exp_q[p])) begin
                    err_inc = err_inc + CNT_W'(1);
                end
                exp_d[p] = exp_q[p] + PAY_W'(NUM_PORTS);
            end
        end
        rx_d    = rx_q + rx_inc;
        err_sum = {1'b0, err_q} + {1'b0, err_inc};
        err_d   = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_CFG;
                    umb_lo_d  = 3'(UMBRAL_BAJO);
                    umb_hi_d  = 3'(UMBRAL_ALTO);
                    tout_d    = 1'b0;
                    rx_d      = '0;
                    err_d     = '0;
                    sent_d    = '0;
                    num_d     = cfg_num_words;
                    gap_cfg_d = cfg_gap;
                    gap_d     = '0;
                    idle_d    = '0;
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        exp_d[p] = PAY_W'(SEED + p);
                    end
                end
            end
            ST_CFG: state_d = ST_INIT;
            ST_INIT: begin
                state_d = ST_WAIT;
                wait_d  = '0;
            end
            ST_WAIT: begin
                if (wait_q == WAIT_W'(INIT_WAIT - 1)) begin
                    state_d = (num_q == '0) ? ST_DRAIN : ST_PUSH;
                    idle_d  = '0;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_PUSH: begin
                // Backpressure freezes both the push and the gap countdown.
                if (!fifo_almost_full) begin
                    if (gap_q != '0) begin
                        gap_d = gap_q - 4'd1;
                    end else begin
                        push_d = 1'b1;
                        data_d = push_word;
                        sent_d = sent_inc;
                        gap_d  = gap_cfg_q;
                        if (sent_inc == num_q) begin
                            state_d = ST_DRAIN;
                            idle_d  = '0;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if ((rx_q >= num_q) && (pop_q == '0)) begin
                    state_d = ST_DONE;
                end else if (pop_c != '0) begin
                    idle_d = '0;
                end else if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                    tout_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        init_d = (state_d == ST_INIT);
        done_d = (state_d == ST_DONE);
        busy_d = (state_d == ST_CFG) || (state_d == ST_INIT) || (state_d == ST_WAIT) ||
                 (state_d == ST_PUSH) || (state_d == ST_DRAIN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            umb_lo_q  <= '0;
            umb_hi_q  <= '0;
            init_q    <= 1'b0;
            push_q    <= 1'b0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tout_q    <= 1'b0;
            rx_q      <= '0;
            err_q     <= '0;
            num_q     <= '0;
            sent_q    <= '0;
            gap_cfg_q <= '0;
            gap_q     <= '0;
            wait_q    <= '0;
            idle_q    <= '0;
            exp_q     <= '0;
            pop_q     <= '0;
        end else begin
            state_q   <= state_d;
            umb_lo_q  <= umb_lo_d;
            umb_hi_q  <= umb_hi_d;
            init_q    <= init_d;
            push_q    <= push_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            tout_q    <= tout_d;
            rx_q      <= rx_d;
            err_q     <= err_d;
            num_q     <= num_d;
            sent_q    <= sent_d;
            gap_cfg_q <= gap_cfg_d;
            gap_q     <= gap_d;
            wait_q    <= wait_d;
            idle_q    <= idle_d;
            exp_q     <= exp_d;
            pop_q     <= pop_d;
        end
    end

    assign Umbral_bajo   = umb_lo_q;
    assign Umbral_alto   = umb_hi_q;
    assign init          = init_q;
    assign pushIn        = push_q;
    assign dataInputFIFO = data_q;
    assign popOut        = pop_c;
    assign busy          = busy_q;
    assign done          = done_q;
    assign timeout       = tout_q;
    assign rx_count      = rx_q;
    assign err_count     = err_q;

endmodule
